mult_op_sequencer: RTL and testbench

//  Front-end issue stage for the 4x4 serial shift-add multiplier (mult_4x4).

---
 rtl/mult_op_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_mult_op_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_op_sequencer.sv
// mult_op_sequencer: issue stage in front of the 4x4 serial shift-add multiplier.
// Operand pairs arrive over valid/ready and are buffered in a DEPTH-entry FIFO.
// One op at a time is driven onto the multiplier through its reset/A/B/Finish
// handshake. The 8-bit product is captured into a valid/ready result register.
// Results come back in issue order because only one op is ever in flight.
//
// Optional build macro:
//   MULT_TIMEOUT_EN - adds an 8-bit per-op watchdog. When it reaches TIMEOUT
//                     cycles, the op is dropped and the sticky timeout_err is set.
//                     Without the macro, the FSM waits for the multiplier forever
//                     and timeout_err is tied low.
module mult_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic                     mul_rst,
  output logic [3:0]               mul_a,
  output logic [3:0]               mul_b,
  input  logic                     mul_finish,
  input  logic [7:0]               mul_product,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_product,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Each FIFO entry is {a, b}. The storage is data only and is never reset.
  logic [7:0]        fifo_mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // op_done: the multiplier raised Finish while we were waiting for it.
  // op_abort: the watchdog gave up on the current op.
  logic              op_done;
  logic              op_abort;

  assign in_ready   = (fifo_count < CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_count == '0);

  // FIFO storage write; the full check lives in in_ready, so there is no bypass path.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic. A watchdog abort overrides the normal progression.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!mul_finish) begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (mul_finish) begin
          state_nxt = S_IDLE;
        end
      end
      default:     state_nxt = S_IDLE;
    endcase
    if (op_abort) begin
      state_nxt = S_IDLE;
    end
  end

  // FSM outputs: the pop/issue decision, the completion strobe and busy.
  always_comb begin
    busy    = (state != S_IDLE);
    pop     = (state == S_IDLE) && !fifo_empty && !res_valid;
    op_done = (state == S_WAIT_DONE) && mul_finish;
  end

  // Restart pulse is registered off the next state, so it is high exactly while in LAUNCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_rst <= 1'b1;
    end else begin
      mul_rst <= (state_nxt == S_LAUNCH);
    end
  end

  // Operand registers load only on the pop. They stay frozen until the next op is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (pop) begin
      {mul_a, mul_b} <= fifo_mem[rd_ptr];
    end
  end

  // Result register. It is set on completion and cleared when the consumer accepts it.
  // A reset in mid-op abandons the op, so a stale result can never appear.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_product <= '0;
    end else if (op_done) begin
      res_valid   <= 1'b1;
      res_product <= mul_product;
    end else if (res_valid && res_ready) begin
      res_valid   <= 1'b0;
    end
  end

`ifdef MULT_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt;
  logic       wd_counting;
  logic       wd_hit;

  // wd_hit fires on the TIMEOUT-th counted cycle. A completion in that same cycle wins.
  assign wd_counting = (state == S_LOAD) || (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign wd_hit      = wd_counting && (wd_cnt == WD_LAST);
  assign op_abort    = wd_hit && !op_done;

  // Watchdog counter: restarted as each op enters LAUNCH, advanced while the multiplier owns the op.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state_nxt == S_LAUNCH) begin
      wd_cnt <= '0;
    end else if (wd_counting && !wd_hit) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (op_abort) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign op_abort    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_op_sequencer.sv
// tb_mult_op_sequencer: directed bench for mult_op_sequencer.
// It contains a behavioural 4x4 multiplier (5..9 cycle latency, set by A's bit count).
// The reference model is a pair of operand queues: ops accepted but not yet
// issued, and the op in flight. A negedge compare process checks the DUT against
// those queues every cycle. Directed tests add literal expectations.
// Build with +define+MULT_TIMEOUT_EN to add the watchdog scenario.
module tb_mult_op_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       mul_rst;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_finish = 1'b1;
  logic [7:0] mul_product = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_product;
  logic       busy;
  logic [2:0] fifo_count;
  logic       timeout_err;

  int vectors = 0;
  int miscompares = 0;

  mult_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
    .mul_finish(mul_finish), .mul_product(mul_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .busy(busy), .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: the reset pulse idles it, the next cycle loads A/B,
  // then Finish stays low for 4 + popcount(A) cycles before the product appears.
  logic       m_pend = 1'b0;
  logic       m_run = 1'b0;
  logic       stuck = 1'b0;
  int         m_cnt = 0;
  logic [3:0] m_a = '0;
  logic [3:0] m_b = '0;

  always @(posedge clk) begin
    if (mul_rst === 1'b1) begin
      mul_finish <= 1'b1;
      m_pend     <= 1'b1;
      m_run      <= 1'b0;
    end else if (m_pend) begin
      m_pend <= 1'b0;
      if (!stuck) begin
        mul_finish <= 1'b0;
        m_run      <= 1'b1;
        m_cnt      <= 3 + $countones(mul_a);
        m_a        <= mul_a;
        m_b        <= mul_b;
      end
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_run       <= 1'b0;
        mul_finish  <= 1'b1;
        mul_product <= 8'(m_a) * 8'(m_b);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Reference model state.
  typedef struct packed { logic [3:0] a; logic [3:0] b; } op_t;
  op_t  issue_q[$];
  op_t  fly_q[$];
  op_t  pend_op = '0;
  logic chk_en = 1'b0;
  logic rst_q = 1'b1;
  logic pend_push = 1'b0;
  logic launch_q = 1'b0;
  logic busy_q = 1'b0;
  logic rv_q = 1'b0;
  logic rr_q = 1'b0;
  logic terr_q = 1'b0;
  logic [3:0] a_q = '0;
  logic [3:0] b_q = '0;
  logic [7:0] p_q = '0;
  int   n_launch = 0;
  int   n_rst_cycles = 0;

  // Per-cycle compare of the DUT against the queue model. It runs on the negedge,
  // when this cycle's outputs and the inputs for the next posedge are both stable.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_q) begin
        issue_q.delete();
        fly_q.delete();
      end else begin
        if (pend_push) issue_q.push_back(pend_op);
        if (mul_rst) n_rst_cycles <= n_rst_cycles + 1;
        if (busy && mul_rst) begin
          n_launch <= n_launch + 1;
          check("mul_rst_width", launch_q, 0);
          check("launch_has_op", issue_q.size() > 0, 1);
          check("one_in_flight", fly_q.size(), 0);
          if (issue_q.size() > 0) begin
            check("launch_a", mul_a, issue_q[0].a);
            check("launch_b", mul_b, issue_q[0].b);
            fly_q.push_back(issue_q.pop_front());
          end
        end
        if (!busy) check("mul_rst_idle", mul_rst, 0);
        check("fifo_count", fifo_count, issue_q.size());
        check("in_ready", in_ready, issue_q.size() < DEPTH);
        if (busy && busy_q) begin
          check("mul_a_stable", mul_a, a_q);
          check("mul_b_stable", mul_b, b_q);
        end
        if (rv_q && !rr_q) begin
          check("res_valid_hold", res_valid, 1);
          check("res_product_hold", res_product, p_q);
        end
        if (res_valid && !rv_q) check("busy_low_at_result", busy, 0);
        if (res_valid && res_ready) begin
          check("result_expected", fly_q.size() > 0, 1);
          if (fly_q.size() > 0) begin
            check("res_product", res_product, int'(fly_q[0].a) * int'(fly_q[0].b));
            void'(fly_q.pop_front());
          end
        end
`ifdef MULT_TIMEOUT_EN
        if (timeout_err && !terr_q && fly_q.size() > 0) void'(fly_q.pop_front());
`else
        check("timeout_err_tied", timeout_err, 0);
`endif
      end
      pend_op   <= op_t'({in_a, in_b});
      pend_push <= in_valid && in_ready && !reset;
      launch_q  <= busy && mul_rst;
      busy_q    <= busy;
      a_q       <= mul_a;
      b_q       <= mul_b;
      rv_q      <= res_valid;
      rr_q      <= res_ready;
      p_q       <= res_product;
      terr_q    <= timeout_err;
      rst_q     <= reset;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one pair and hold it until accepted. Returns at posedge+1 after the
  // accepting edge, so consecutive calls give back-to-back pushes.
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [7:0] exp, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < budget);
    check({name, "_seen"}, res_valid, 1);
    check(name, res_product, exp);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_mul_rst"}, mul_rst, 1);
    check({pfx, "_in_ready"}, in_ready, 1);
    check({pfx, "_res_valid"}, res_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_fifo_count"}, fifo_count, 0);
    check({pfx, "_mul_a"}, mul_a, 0);
    check({pfx, "_mul_b"}, mul_b, 0);
    check({pfx, "_res_product"}, res_product, 0);
    check({pfx, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int l0;
    int r0;
    int n;
    int stale;

    step(3);
    check_reset_values("rst");
    chk_en = 1'b1;
    reset = 1'b0;
    step(6);

    // Single op (6,2): launch two cycles after acceptance, one result pulse of 12.
    res_ready = 1'b1;
    push(4'd6, 4'd2);
    @(negedge clk);
    check("t1_idle_at_t1", busy, 0);
    @(negedge clk);
    check("t1_launch_at_t2", {busy, mul_rst}, 2'b11);
    check("t1_mul_a", mul_a, 6);
    check("t1_mul_b", mul_b, 2);
    wait_res("t1_res", 8'd12, 40);
    @(negedge clk);
    check("t1_single_pulse", res_valid, 0);
    check("t1_busy_after", busy, 0);
    step(3);

    // Back-to-back ops: results in order, one restart cycle per op.
    l0 = n_launch;
    r0 = n_rst_cycles;
    push(4'd15, 4'd15);
    push(4'd0, 4'd0);
    wait_res("t2_first", 8'd225, 60);
    wait_res("t2_second", 8'd0, 60);
    step(3);
    check("t2_launches", n_launch - l0, 2);
    check("t2_rst_cycles", n_rst_cycles - r0, 2);

    // Consumer stalled: the FIFO fills to DEPTH and the sixth push waits.
    res_ready = 1'b0;
    fork
      begin
        push(4'd1, 4'd1);
        push(4'd2, 4'd3);
        push(4'd4, 4'd5);
        push(4'd7, 4'd8);
        push(4'd10, 4'd11);
        push(4'd12, 4'd13);
      end
      begin
        step(45);
        @(negedge clk);
        check("t3_fifo_full", fifo_count, 4);
        check("t3_in_ready_low", in_ready, 0);
        check("t3_held_valid", res_valid, 1);
        check("t3_held_product", res_product, 1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_res("t3_r1", 8'd1, 60);
        wait_res("t3_r2", 8'd6, 60);
        wait_res("t3_r3", 8'd20, 60);
        wait_res("t3_r4", 8'd56, 60);
        wait_res("t3_r5", 8'd110, 60);
        wait_res("t3_r6", 8'd156, 60);
      end
    join
    step(3);

    // Push and pop on the same edge: occupancy is unchanged and (9,7) gives 63 at the tail.
    res_ready = 1'b0;
    push(4'd2, 4'd2);
    push(4'd3, 4'd3);
    push(4'd1, 4'd5);
    push(4'd5, 4'd5);
    step(40);
    @(negedge clk);
    check("t6_count_before", fifo_count, 3);
    check("t6_held_product", res_product, 4);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    push(4'd9, 4'd7);
    @(negedge clk);
    check("t6_count_unchanged", fifo_count, 3);
    check("t6_launch", {busy, mul_rst}, 2'b11);
    wait_res("t6_r1", 8'd9, 60);
    wait_res("t6_r2", 8'd5, 60);
    wait_res("t6_r3", 8'd25, 60);
    wait_res("t6_r4", 8'd63, 60);
    step(3);

    // Reset during WAIT_DONE: outputs return to reset values and the op is never reported.
    push(4'd15, 4'd15);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && !mul_finish) && n < 40);
    check("t4_reached_wait", busy && !mul_finish, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("t4");
    reset = 1'b0;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) stale++;
    end
    check("t4_no_stale_result", stale, 0);
    step(1);
    push(4'd3, 4'd5);
    wait_res("t4_after_reset", 8'd15, 40);
    step(3);

`ifdef MULT_TIMEOUT_EN
    // Multiplier never drops Finish: the watchdog drops the op after 32 counted cycles.
    stuck = 1'b1;
    push(4'd4, 4'd4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && mul_rst) && n < 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_err && n < 80);
    check("t5_timeout_cycles", n, 33);
    check("t5_timeout_err", timeout_err, 1);
    check("t5_idle", busy, 0);
    check("t5_no_result", res_valid, 0);
    stuck = 1'b0;
    step(1);
    push(4'd2, 4'd7);
    wait_res("t5_next_op", 8'd14, 40);
    check("t5_err_sticky", timeout_err, 1);
    step(3);
`endif

    step(5);
    check("end_issue_q_empty", issue_q.size(), 0);
    check("end_fly_q_empty", fly_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
